tick_stopwatch: RTL and testbench

//  Consumer stage for the flexible_clock divider output. It runs in the basys_clk domain and

---
 rtl/tick_stopwatch.sv | 104 ++++++++++
 tb/tb_tick_stopwatch.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_stopwatch.sv
// MM:SS BCD stopwatch advanced by rising edges of a divided-clock level.
// Start/pause/clear control; rollover pulses on the 59:59 -> 00:00 wrap.
module tick_stopwatch #(
  parameter int unsigned TICKS_PER_UNIT = 1
) (
  input  logic        basys_clk,
  input  logic        reset,
  input  logic        slow_clk,
  input  logic        start_stop,
  input  logic        clear,
  output logic [15:0] digits,
  output logic        running,
  output logic        paused,
  output logic        rollover
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [15:0] PRE_MAX = 16'(TICKS_PER_UNIT - 1);

  state_t      state;
  state_t      state_nx;
  logic        slow_prev;
  logic        tick;
  logic        count_en;
  logic        unit_done;
  logic        wrap;
  logic [15:0] prescaler;
  logic [15:0] digits_inc;

  assign tick      = slow_clk & ~slow_prev;
  assign count_en  = (state == RUN) & tick & ~clear;
  assign unit_done = count_en & (prescaler == PRE_MAX);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_stop) state_nx = RUN;
      RUN:     if (start_stop) state_nx = PAUSE;
      PAUSE:   if (start_stop) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  // ripple-carry BCD increment across the four digits
  always_comb begin
    digits_inc = digits;
    wrap       = 1'b0;
    if (digits[3:0] != 4'd9) begin
      digits_inc[3:0] = digits[3:0] + 4'd1;
    end else begin
      digits_inc[3:0] = 4'd0;
      if (digits[7:4] != 4'd5) begin
        digits_inc[7:4] = digits[7:4] + 4'd1;
      end else begin
        digits_inc[7:4] = 4'd0;
        if (digits[11:8] != 4'd9) begin
          digits_inc[11:8] = digits[11:8] + 4'd1;
        end else begin
          digits_inc[11:8] = 4'd0;
          if (digits[15:12] != 4'd5) begin
            digits_inc[15:12] = digits[15:12] + 4'd1;
          end else begin
            digits_inc[15:12] = 4'd0;
            wrap              = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      state     <= IDLE;
      slow_prev <= slow_clk;
      prescaler <= '0;
      digits    <= '0;
      running   <= 1'b0;
      paused    <= 1'b0;
      rollover  <= 1'b0;
    end else begin
      slow_prev <= slow_clk;
      state     <= state_nx;
      running   <= (state_nx == RUN);
      paused    <= (state_nx == PAUSE);
      rollover  <= unit_done & wrap;
      if (clear) begin
        prescaler <= '0;
        digits    <= '0;
      end else if (unit_done) begin
        prescaler <= '0;
        digits    <= digits_inc;
      end else if (count_en) begin
        prescaler <= prescaler + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch: two instances (2 and 1 ticks per unit)
// share stimulus and are checked against a seconds-count model.
module tb_tick_stopwatch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        slow = 1'b0;
  logic        ss = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] dig2, dig1;
  logic        run2, run1, pau2, pau1, rol2, rol1;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  tick_stopwatch #(.TICKS_PER_UNIT(2)) dut2 (
    .basys_clk(clk), .reset(reset), .slow_clk(slow),
    .start_stop(ss), .clear(clr), .digits(dig2),
    .running(run2), .paused(pau2), .rollover(rol2)
  );

  tick_stopwatch #(.TICKS_PER_UNIT(1)) dut1 (
    .basys_clk(clk), .reset(reset), .slow_clk(slow),
    .start_stop(ss), .clear(clr), .digits(dig1),
    .running(run1), .paused(pau1), .rollover(rol1)
  );

  // model: mode 0 idle, 1 run, 2 pause; ticks counted since clear
  int   m_mode;
  int   m_ticks [2];
  bit   m_roll [2];
  bit   m_prev;
  int   tpu [2] = '{2, 1};

  always @(posedge clk) begin
    if (reset) begin
      m_mode  = 0;
      m_ticks = '{0, 0};
      m_roll  = '{0, 0};
      m_prev  = slow;
    end else begin
      bit tk;
      tk      = slow & ~m_prev;
      m_prev  = slow;
      m_roll  = '{0, 0};
      if (clr) begin
        m_mode  = 0;
        m_ticks = '{0, 0};
      end else begin
        if (tk && m_mode == 1) begin
          for (int k = 0; k < 2; k++) begin
            m_ticks[k]++;
            if (m_ticks[k] % (tpu[k] * 3600) == 0) m_roll[k] = 1;
          end
        end
        if (ss) m_mode = (m_mode == 1) ? 2 : 1;
      end
    end
  end

  function automatic logic [15:0] exp_dig(int k);
    int s, mm, sc;
    s  = (m_ticks[k] / tpu[k]) % 3600;
    mm = s / 60;
    sc = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic lvl);
    reset = 1'b1;
    slow  = lvl;
    ss    = 1'b0;
    clr   = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
  endtask

  task automatic rise();
    slow = 1'b1;
    cyc();
    slow = 1'b0;
    cyc();
  endtask

  task automatic press();
    ss = 1'b1;
    cyc();
    ss = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    repeat (4) cyc();
    vecs++;
    if (dig1 !== 16'h0000) begin
      errs++;
      $display("FAIL reset_digits got %h exp 0000", dig1);
    end
    vecs++;
    if (run1 !== 1'b0 || pau1 !== 1'b0 || rol1 !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags got %b%b%b exp 000", run1, pau1, rol1);
    end
    // slow stays high: pressing start must still see no edge
    press();
    repeat (3) cyc();
    vecs++;
    if (dig1 !== 16'h0000 || run1 !== 1'b1) begin
      errs++;
      $display("FAIL reset_no_edge got %h/%b exp 0000/1", dig1, run1);
    end
    slow = 1'b0;
    cyc();
  endtask

  task automatic test_prescale();
    do_reset(1'b0);
    press();
    repeat (6) rise();
    vecs++;
    if (dig2 !== 16'h0003 || run2 !== 1'b1) begin
      errs++;
      $display("FAIL prescale2 got %h/%b exp 0003/1", dig2, run2);
    end
    vecs++;
    if (dig1 !== 16'h0006) begin
      errs++;
      $display("FAIL prescale1 got %h exp 0006", dig1);
    end
  endtask

  task automatic test_rollover();
    do_reset(1'b0);
    press();
    repeat (3598) rise();
    vecs++;
    if (dig1 !== 16'h5958) begin
      errs++;
      $display("FAIL preload got %h exp 5958", dig1);
    end
    rise();
    vecs++;
    if (dig1 !== 16'h5959 || rol1 !== 1'b0) begin
      errs++;
      $display("FAIL at_5959 got %h/%b exp 5959/0", dig1, rol1);
    end
    slow = 1'b1;
    cyc();
    vecs++;
    if (dig1 !== 16'h0000 || rol1 !== 1'b1) begin
      errs++;
      $display("FAIL wrap got %h/%b exp 0000/1", dig1, rol1);
    end
    slow = 1'b0;
    cyc();
    vecs++;
    if (rol1 !== 1'b0) begin
      errs++;
      $display("FAIL wrap_pulse got %b exp 0", rol1);
    end
    vecs++;
    if (dig2 !== 16'h3000 || rol2 !== 1'b0) begin
      errs++;
      $display("FAIL wrap_slow got %h/%b exp 3000/0", dig2, rol2);
    end
  endtask

  task automatic test_pause();
    do_reset(1'b0);
    press();
    rise();
    press();
    repeat (5) rise();
    vecs++;
    if (dig2 !== 16'h0000 || pau2 !== 1'b1 || run2 !== 1'b0) begin
      errs++;
      $display("FAIL pause_hold got %h/%b exp 0000/1", dig2, pau2);
    end
    press();
    rise();
    vecs++;
    if (dig2 !== 16'h0001 || run2 !== 1'b1) begin
      errs++;
      $display("FAIL pause_resume got %h/%b exp 0001/1", dig2, run2);
    end
    vecs++;
    if (dig1 !== 16'h0002) begin
      errs++;
      $display("FAIL pause_resume1 got %h exp 0002", dig1);
    end
  endtask

  task automatic test_clear_priority();
    do_reset(1'b0);
    press();
    repeat (3) rise();
    clr  = 1'b1;
    ss   = 1'b1;
    slow = 1'b1;
    cyc();
    clr  = 1'b0;
    ss   = 1'b0;
    vecs++;
    if (dig1 !== 16'h0000 || run1 !== 1'b0 || pau1 !== 1'b0) begin
      errs++;
      $display("FAIL clear_prio got %h/%b%b exp 0000/00", dig1, run1, pau1);
    end
    slow = 1'b0;
    cyc();
    press();
    rise();
    vecs++;
    if (dig1 !== 16'h0001 || dig2 !== 16'h0000) begin
      errs++;
      $display("FAIL clear_presc got %h/%h exp 0001/0000", dig1, dig2);
    end
  endtask

  task automatic test_tick_with_pause();
    do_reset(1'b0);
    press();
    repeat (3) rise();
    slow = 1'b1;
    ss   = 1'b1;
    cyc();
    ss   = 1'b0;
    slow = 1'b0;
    vecs++;
    if (dig1 !== 16'h0004 || pau1 !== 1'b1) begin
      errs++;
      $display("FAIL tick_pause got %h/%b exp 0004/1", dig1, pau1);
    end
    vecs++;
    if (dig2 !== 16'h0002) begin
      errs++;
      $display("FAIL tick_pause2 got %h exp 0002", dig2);
    end
    cyc();
    slow = 1'b1;
    ss   = 1'b1;
    cyc();
    ss   = 1'b0;
    slow = 1'b0;
    cyc();
    vecs++;
    if (dig1 !== 16'h0004 || run1 !== 1'b1) begin
      errs++;
      $display("FAIL tick_resume got %h/%b exp 0004/1", dig1, run1);
    end
  endtask

  task automatic test_random();
    do_reset(1'($urandom_range(0, 1)));
    for (int i = 0; i < 3000; i++) begin
      slow = 1'($urandom_range(0, 1));
      ss   = ($urandom_range(0, 15) == 0);
      clr  = ($urandom_range(0, 63) == 0);
      cyc();
      vecs++;
      if (dig2 !== exp_dig(0) || dig1 !== exp_dig(1)) begin
        errs++;
        $display("FAIL rnd_digits@%0d got %h/%h exp %h/%h",
                 i, dig2, dig1, exp_dig(0), exp_dig(1));
      end
      vecs++;
      if (run1 !== (m_mode == 1) || pau1 !== (m_mode == 2) ||
          run2 !== (m_mode == 1) || pau2 !== (m_mode == 2)) begin
        errs++;
        $display("FAIL rnd_state@%0d got %b%b%b%b exp mode %0d",
                 i, run2, pau2, run1, pau1, m_mode);
      end
      vecs++;
      if (rol2 !== m_roll[0] || rol1 !== m_roll[1]) begin
        errs++;
        $display("FAIL rnd_roll@%0d got %b%b exp %b%b",
                 i, rol2, rol1, m_roll[0], m_roll[1]);
      end
    end
    ss  = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_rollover();
    test_pause();
    test_clear_priority();
    test_tick_with_pause();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
